// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush enables,
// EX-stage forwarding selects, data-memory wait handshake with timeout, perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs1_d_i,
  input  logic [4:0]  rs2_d_i,
  input  logic [4:0]  rs1_e_i,
  input  logic [4:0]  rs2_e_i,
  input  logic [4:0]  rd_e_i,
  input  logic        MemRead_e_i,
  input  logic        PCSrc_e_i,
  input  logic [4:0]  rd_m_i,
  input  logic        RegWrite_m_i,
  input  logic [4:0]  rd_w_i,
  input  logic        RegWrite_w_i,
  input  logic        MemAccess_m_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushW_o,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state_r;
  logic [15:0] wait_cnt_r;
  logic        mem_err_r;
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  logic        memstall_s;
  logic        req_s;
  logic        lwstall_s;
  logic        branch_s;
  logic        stall_fd_s;
  logic        flush_e_s;

  // MEM has priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Memory request and memory-stall decode from FSM state.
  always_comb begin
    memstall_s = 1'b0;
    req_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_s      = MemAccess_m_i;
        memstall_s = MemAccess_m_i & ~dmem_ack_i;
      end
      ST_WAIT: begin
        req_s      = 1'b1;
        memstall_s = ~dmem_ack_i;
      end
      ST_ERR: begin
        req_s      = 1'b0;
        memstall_s = 1'b1;
      end
      default: begin
        req_s      = 1'b0;
        memstall_s = 1'b1;
      end
    endcase
  end

  assign lwstall_s = MemRead_e_i && (rd_e_i != 5'd0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  // A memory stall freezes EX, so a resolved branch waits there until released.
  assign branch_s  = PCSrc_e_i & ~memstall_s;

  // Stall/flush priority: memory stall, then branch, then load-use.
  always_comb begin
    stall_fd_s = 1'b0;
    flush_e_s  = 1'b0;
    if (memstall_s) begin
      stall_fd_s = 1'b1;
      flush_e_s  = 1'b0;
    end else if (PCSrc_e_i) begin
      stall_fd_s = 1'b0;
      flush_e_s  = 1'b1;
    end else if (lwstall_s) begin
      stall_fd_s = 1'b1;
      flush_e_s  = 1'b1;
    end else begin
      stall_fd_s = 1'b0;
      flush_e_s  = 1'b0;
    end
  end

  assign dmem_req_o  = req_s;
  assign StallF_o    = stall_fd_s;
  assign StallD_o    = stall_fd_s;
  assign StallE_o    = memstall_s;
  assign StallM_o    = memstall_s;
  assign FlushD_o    = branch_s;
  assign FlushE_o    = flush_e_s;
  assign FlushW_o    = memstall_s;
  assign ForwardAE_o = fwd_sel(rs1_e_i, rd_m_i, RegWrite_m_i, rd_w_i, RegWrite_w_i);
  assign ForwardBE_o = fwd_sel(rs2_e_i, rd_m_i, RegWrite_m_i, rd_w_i, RegWrite_w_i);
  assign mem_err_o   = mem_err_r;
  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

  // Memory handshake FSM, sticky error flag and performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 16'd0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_fd_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (branch_s) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (MemAccess_m_i && !dmem_ack_i) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= 16'd1;
          end
        end
        ST_WAIT: begin
          if (dmem_ack_i) begin
            state_r <= ST_IDLE;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_r   <= ST_ERR;
            mem_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_ERR: begin
          mem_err_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_ERR;
          mem_err_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  rs1_d_i = 5'd0, rs2_d_i = 5'd0, rs1_e_i = 5'd0, rs2_e_i = 5'd0, rd_e_i = 5'd0;
  logic        MemRead_e_i = 1'b0, PCSrc_e_i = 1'b0;
  logic [4:0]  rd_m_i = 5'd0, rd_w_i = 5'd0;
  logic        RegWrite_m_i = 1'b0, RegWrite_w_i = 1'b0, MemAccess_m_i = 1'b0, dmem_ack_i = 1'b0;
  logic        dmem_req_o, StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        mem_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: outstanding request, WAIT cycles so far, error, counters.
  bit          m_busy = 1'b0;
  int          m_waited = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
    .rd_e_i(rd_e_i), .MemRead_e_i(MemRead_e_i), .PCSrc_e_i(PCSrc_e_i),
    .rd_m_i(rd_m_i), .RegWrite_m_i(RegWrite_m_i), .rd_w_i(rd_w_i), .RegWrite_w_i(RegWrite_w_i),
    .MemAccess_m_i(MemAccess_m_i), .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit memstall_ref();
    if (m_err) return 1'b1;
    if (m_busy) return !dmem_ack_i;
    return MemAccess_m_i && !dmem_ack_i;
  endfunction

  function automatic bit lw_ref();
    return MemRead_e_i && rd_e_i != 5'd0 && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWrite_m_i && rd_m_i != 5'd0 && rd_m_i == rs) return 2'd2;
    if (RegWrite_w_i && rd_w_i != 5'd0 && rd_w_i == rs) return 2'd1;
    return 2'd0;
  endfunction

  // {req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, FwdA, FwdB, mem_err}
  function automatic logic [12:0] expect_outs();
    bit ms, br, lw, req;
    ms  = memstall_ref();
    br  = PCSrc_e_i && !ms;
    lw  = lw_ref() && !ms && !PCSrc_e_i;
    req = m_err ? 1'b0 : (m_busy ? 1'b1 : MemAccess_m_i);
    return {req, ms | lw, ms | lw, ms, ms, br, br | lw, ms,
            fwd_ref(rs1_e_i), fwd_ref(rs2_e_i), m_err};
  endfunction

  wire [12:0] obs = {dmem_req_o, StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o,
                     FlushW_o, ForwardAE_o, ForwardBE_o, mem_err_o};

  task automatic model_clock();
    bit ms;
    ms = memstall_ref();
    if (rst_i) begin
      m_busy = 1'b0; m_waited = 0; m_err = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
    end else begin
      if (ms || (lw_ref() && !PCSrc_e_i)) m_stall = m_stall + 32'd1;
      if (PCSrc_e_i && !ms) m_flush = m_flush + 32'd1;
      if (m_err) begin
        m_err = 1'b1;
      end else if (m_busy) begin
        if (dmem_ack_i) m_busy = 1'b0;
        else if (m_waited == TO) begin m_busy = 1'b0; m_err = 1'b1; end
        else m_waited++;
      end else if (MemAccess_m_i && !dmem_ack_i) begin
        m_busy = 1'b1; m_waited = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d_i = 5'd0; rs2_d_i = 5'd0; rs1_e_i = 5'd0; rs2_e_i = 5'd0; rd_e_i = 5'd0;
    MemRead_e_i = 1'b0; PCSrc_e_i = 1'b0; rd_m_i = 5'd0; rd_w_i = 5'd0;
    RegWrite_m_i = 1'b0; RegWrite_w_i = 1'b0; MemAccess_m_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk_i);
    tests_run++;
    if (obs !== 13'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b expected %b", obs, 13'd0);
    end
    tests_run++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      tests_failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_forwarding();
    reset_dut();
    rs1_e_i = 5'd5; rs2_e_i = 5'd5; rd_m_i = 5'd5; RegWrite_m_i = 1'b1; rd_w_i = 5'd5; RegWrite_w_i = 1'b1;
    #1;
    tests_run++;
    if (ForwardAE_o !== 2'b10 || ForwardBE_o !== 2'b10) begin
      tests_failed++; $display("FAIL fwd_mem_priority: got %b/%b expected 10/10", ForwardAE_o, ForwardBE_o);
    end
    RegWrite_m_i = 1'b0;
    #1;
    tests_run++;
    if (ForwardAE_o !== 2'b01) begin
      tests_failed++; $display("FAIL fwd_wb: got %b expected 01", ForwardAE_o);
    end
    rd_m_i = 5'd0; rd_w_i = 5'd0; rs1_e_i = 5'd0; RegWrite_m_i = 1'b1;
    #1;
    tests_run++;
    if (ForwardAE_o !== 2'b00) begin
      tests_failed++; $display("FAIL fwd_x0: got %b expected 00", ForwardAE_o);
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    MemRead_e_i = 1'b1; rd_e_i = 5'd3; rs2_d_i = 5'd3;
    @(negedge clk_i);
    tests_run++;
    if ({StallF_o, StallD_o, FlushE_o, StallE_o, FlushD_o} !== 5'b11100) begin
      tests_failed++;
      $display("FAIL lw_stall: got %b expected 11100", {StallF_o, StallD_o, FlushE_o, StallE_o, FlushD_o});
    end
    tick();
    clear_inputs();
    @(negedge clk_i);
    tests_run++;
    if (StallF_o !== 1'b0 || stall_cnt_o !== 32'd1) begin
      tests_failed++; $display("FAIL lw_one_cycle: got stall=%b cnt=%0d expected 0/1", StallF_o, stall_cnt_o);
    end
    MemRead_e_i = 1'b1; rd_e_i = 5'd0; rs2_d_i = 5'd0;
    @(negedge clk_i);
    tests_run++;
    if (StallF_o !== 1'b0 || FlushE_o !== 1'b0) begin
      tests_failed++; $display("FAIL lw_rd0: got stall=%b flushE=%b expected 0/0", StallF_o, FlushE_o);
    end
    tick();
  endtask

  task automatic test_branch_vs_lu();
    reset_dut();
    MemRead_e_i = 1'b1; rd_e_i = 5'd7; rs1_d_i = 5'd7; PCSrc_e_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({FlushD_o, FlushE_o, StallF_o, StallD_o} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL branch_wins: got %b expected 1100", {FlushD_o, FlushE_o, StallF_o, StallD_o});
    end
    tick();
    clear_inputs();
    @(negedge clk_i);
    tests_run++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd0) begin
      tests_failed++; $display("FAIL branch_counts: got %0d/%0d expected 1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    reset_dut();
    MemAccess_m_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tests_run++;
      if ({dmem_req_o, StallF_o, StallM_o, FlushW_o} !== 4'b1111) begin
        tests_failed++;
        $display("FAIL memwait_stall[%0d]: got %b expected 1111", i, {dmem_req_o, StallF_o, StallM_o, FlushW_o});
      end
      tick();
    end
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({dmem_req_o, StallF_o, StallM_o, FlushW_o} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL memwait_ack: got %b expected 1000", {dmem_req_o, StallF_o, StallM_o, FlushW_o});
    end
    tick();
    clear_inputs();
    @(negedge clk_i);
    tests_run++;
    if (dmem_req_o !== 1'b0 || stall_cnt_o !== 32'd3) begin
      tests_failed++; $display("FAIL memwait_done: got req=%b cnt=%0d expected 0/3", dmem_req_o, stall_cnt_o);
    end
    MemAccess_m_i = 1'b1; dmem_ack_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({dmem_req_o, StallF_o} !== 2'b10) begin
      tests_failed++; $display("FAIL zero_wait: got %b expected 10", {dmem_req_o, StallF_o});
    end
    tick();
  endtask

  task automatic test_branch_defer();
    reset_dut();
    MemAccess_m_i = 1'b1; PCSrc_e_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      tests_run++;
      if ({FlushD_o, FlushE_o, StallE_o} !== 3'b001) begin
        tests_failed++; $display("FAIL defer_hold[%0d]: got %b expected 001", i, {FlushD_o, FlushE_o, StallE_o});
      end
      tick();
    end
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({FlushD_o, FlushE_o, StallE_o} !== 3'b110) begin
      tests_failed++; $display("FAIL defer_release: got %b expected 110", {FlushD_o, FlushE_o, StallE_o});
    end
    tick();
    clear_inputs();
    @(negedge clk_i);
    tests_run++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd2) begin
      tests_failed++; $display("FAIL defer_counts: got %0d/%0d expected 1/2", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    MemAccess_m_i = 1'b1;
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk_i);
      tests_run++;
      if ({dmem_req_o, StallM_o, mem_err_o} !== 3'b110) begin
        tests_failed++; $display("FAIL timeout_wait[%0d]: got %b expected 110", i, {dmem_req_o, StallM_o, mem_err_o});
      end
      tick();
    end
    @(negedge clk_i);
    tests_run++;
    if ({dmem_req_o, StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o, mem_err_o} !== 7'b0111111) begin
      tests_failed++;
      $display("FAIL timeout_err: got %b expected 0111111",
               {dmem_req_o, StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o, mem_err_o});
    end
    tick();
    dmem_ack_i = 1'b1; PCSrc_e_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({mem_err_o, StallF_o, FlushD_o} !== 3'b110) begin
      tests_failed++; $display("FAIL err_sticky: got %b expected 110", {mem_err_o, StallF_o, FlushD_o});
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    tests_run++;
    if ({dmem_req_o, StallF_o, mem_err_o} !== 3'b000 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL err_reset: got %b cnt=%0d/%0d expected 000 0/0",
               {dmem_req_o, StallF_o, mem_err_o}, stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_ack_at_timeout();
    reset_dut();
    MemAccess_m_i = 1'b1;
    for (int i = 0; i < TO; i++) tick();
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({dmem_req_o, StallF_o} !== 2'b10) begin
      tests_failed++; $display("FAIL ack_at_limit: got %b expected 10", {dmem_req_o, StallF_o});
    end
    tick();
    dmem_ack_i = 1'b0; MemAccess_m_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (mem_err_o !== 1'b0 || dmem_req_o !== 1'b0 || stall_cnt_o !== 32'd4) begin
      tests_failed++;
      $display("FAIL ack_at_limit_idle: got err=%b req=%b cnt=%0d expected 0/0/4", mem_err_o, dmem_req_o, stall_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_v;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      rst_i         = ($urandom_range(0, 29) == 0);
      rs1_d_i       = 5'($urandom_range(0, 3)); rs2_d_i = 5'($urandom_range(0, 3));
      rs1_e_i       = 5'($urandom_range(0, 3)); rs2_e_i = 5'($urandom_range(0, 3));
      rd_e_i        = 5'($urandom_range(0, 3)); rd_m_i  = 5'($urandom_range(0, 3));
      rd_w_i        = 5'($urandom_range(0, 3));
      MemRead_e_i   = 1'($urandom_range(0, 1)); PCSrc_e_i    = ($urandom_range(0, 3) == 0);
      RegWrite_m_i  = 1'($urandom_range(0, 1)); RegWrite_w_i = 1'($urandom_range(0, 1));
      MemAccess_m_i = 1'($urandom_range(0, 1)); dmem_ack_i   = ($urandom_range(0, 2) != 0);
      if (c % 97 > 90) dmem_ack_i = 1'b0;
      @(negedge clk_i);
      exp_v = expect_outs();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++; $display("FAIL rand_outs[%0d]: got %b expected %b", c, obs, exp_v);
      end
      tests_run++;
      if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
        tests_failed++;
        $display("FAIL rand_cnts[%0d]: got %0d/%0d expected %0d/%0d", c, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
      end
      tick();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lu();
    test_mem_wait();
    test_branch_defer();
    test_timeout();
    test_ack_at_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
